// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART loopback/echo scheduler.
// The optional transfer counter is enabled with the UART_SCHED_CNT_EN macro.
package uart_sched_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    L_IDLE,
    L_POP,
    L_PUSH
  } lb_state_e;

  typedef enum logic [1:0] {
    T_IDLE,
    T_POP,
    T_START,
    T_WAIT
  } tx_state_e;

endpackage

// File: rtl/uart_tx_issue.sv
// TX issue FSM: pops a byte from the TX FIFO, strobes the transmitter and
// waits for the end-of-frame pulse before considering the next byte.
module uart_tx_issue
  import uart_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              tx_empty,
  input  logic [DATA_W-1:0] tx_rdata,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              tx_pop,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              t_idle
);

  tx_state_e state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= T_IDLE;
      tx_data <= '0;
    end else begin
      state <= state_nxt;
      // FIFO head is captured during the pop cycle so tx_data is stable at start
      if (state == T_POP) tx_data <= tx_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      T_IDLE:  if (en && !tx_empty && !tx_busy) state_nxt = T_POP;
      T_POP:   state_nxt = T_START;
      T_START: state_nxt = T_WAIT;
      T_WAIT:  if (tx_done) state_nxt = T_IDLE;
      default: state_nxt = T_IDLE;
    endcase
  end

  assign tx_pop   = (state == T_POP);
  assign tx_start = (state == T_START);
  assign t_idle   = (state == T_IDLE);

endmodule

// File: rtl/uart_fifo_sched.sv
// Loopback/echo scheduler: moves RX FIFO bytes into the TX FIFO and issues TX
// FIFO bytes to the transmitter. Define UART_SCHED_CNT_EN to add xfer_cnt.
module uart_fifo_sched
  import uart_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rx_empty,
  input  logic [DATA_W-1:0] rx_rdata,
  output logic              rx_pop,
  input  logic              tx_full,
  output logic              tx_push,
  output logic [DATA_W-1:0] tx_wdata,
  input  logic              tx_empty,
  input  logic [DATA_W-1:0] tx_rdata,
  output logic              tx_pop,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
`ifdef UART_SCHED_CNT_EN
  output logic [CNT_W-1:0]  xfer_cnt,
`endif
  output logic              idle
);

  lb_state_e lb_state, lb_next;
  logic      t_idle;

  // tx_wdata doubles as the hold register between pop and push
  always_ff @(posedge clk) begin
    if (rst) begin
      lb_state <= L_IDLE;
      tx_wdata <= '0;
    end else begin
      lb_state <= lb_next;
      if (lb_state == L_POP) tx_wdata <= rx_rdata;
    end
  end

  always_comb begin
    lb_next = lb_state;
    case (lb_state)
      L_IDLE:  if (en && !rx_empty) lb_next = L_POP;
      L_POP:   lb_next = L_PUSH;
      L_PUSH:  if (!tx_full) lb_next = L_IDLE;
      default: lb_next = L_IDLE;
    endcase
  end

  assign rx_pop  = (lb_state == L_POP);
  assign tx_push = (lb_state == L_PUSH) && !tx_full;
  assign idle    = (lb_state == L_IDLE) && t_idle;

`ifdef UART_SCHED_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)          cnt_q <= '0;
    else if (tx_push) cnt_q <= cnt_q + 1'b1;
  end

  assign xfer_cnt = cnt_q;
`endif

  uart_tx_issue #(.DATA_W(DATA_W)) u_tx_issue (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .tx_empty (tx_empty),
    .tx_rdata (tx_rdata),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_pop   (tx_pop),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .t_idle   (t_idle)
  );

endmodule

// File: tb/tb_uart_fifo_sched.sv
// Bench for uart_fifo_sched: FIFO and transmitter models driven from one
// process, scoreboards for pushed and transmitted bytes, directed steps.
module tb_uart_fifo_sched;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, en;
  logic          rx_empty, tx_full, tx_empty, tx_busy, tx_done;
  logic [DW-1:0] rx_rdata, tx_rdata;
  logic          rx_pop, tx_push, tx_pop, tx_start, idle;
  logic [DW-1:0] tx_wdata, tx_data;
`ifdef UART_SCHED_CNT_EN
  logic [15:0]   xfer_cnt;
`endif

  uart_fifo_sched #(.DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rx_empty (rx_empty),
    .rx_rdata (rx_rdata),
    .rx_pop   (rx_pop),
    .tx_full  (tx_full),
    .tx_push  (tx_push),
    .tx_wdata (tx_wdata),
    .tx_empty (tx_empty),
    .tx_rdata (tx_rdata),
    .tx_pop   (tx_pop),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_start (tx_start),
    .tx_data  (tx_data),
`ifdef UART_SCHED_CNT_EN
    .xfer_cnt (xfer_cnt),
`endif
    .idle     (idle)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] exp_push_q[$];
  logic [DW-1:0] exp_start_q[$];

  int            full_hold = 0;
  int            busy_cnt  = 0;
  bit            auto_tx   = 1'b1;
  bit            s_rx_pop, s_tx_pop, s_tx_push, s_tx_start;
  logic [DW-1:0] s_wdata;
  int            n_rx_pop = 0, n_tx_push = 0, n_tx_pop = 0, n_tx_start = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    rx_empty = (rx_q.size() == 0);
    rx_rdata = (rx_q.size() == 0) ? '0 : rx_q[0];
    tx_empty = (tx_q.size() == 0);
    tx_rdata = (tx_q.size() == 0) ? '0 : tx_q[0];
    tx_full  = (full_hold > 0) || (tx_q.size() >= 4);
  endtask

  // FIFO and transmitter state advance just after each rising edge
  task automatic model_update();
    if (s_rx_pop && rx_q.size() > 0) rx_q.delete(0);
    if (s_tx_pop && tx_q.size() > 0) tx_q.delete(0);
    if (s_tx_push) tx_q.push_back(s_wdata);
    if (full_hold > 0) full_hold--;
    if (auto_tx) begin
      tx_done = 1'b0;
      if (s_tx_start) begin
        tx_busy  = 1'b1;
        busy_cnt = 4;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          tx_busy = 1'b0;
          tx_done = 1'b1;
        end
      end
    end
    {s_rx_pop, s_tx_pop, s_tx_push, s_tx_start} = '0;
  endtask

  task automatic monitor();
    logic [DW-1:0] e;
    s_rx_pop   = rx_pop;
    s_tx_pop   = tx_pop;
    s_tx_push  = tx_push;
    s_tx_start = tx_start;
    s_wdata    = tx_wdata;
    if (rx_pop)   n_rx_pop++;
    if (tx_pop)   n_tx_pop++;
    if (tx_push) begin
      n_tx_push++;
      if (exp_push_q.size() == 0) chk("push_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_push_q.pop_front();
        chk("push_data", 32'(tx_wdata), 32'(e));
        exp_start_q.push_back(e);
      end
    end
    if (tx_start) begin
      n_tx_start++;
      if (exp_start_q.size() == 0) chk("start_unexpected", 32'd1, 32'd0);
      else chk("start_data", 32'(tx_data), 32'(exp_start_q.pop_front()));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_update();
    refresh();
    @(negedge clk);
    monitor();
  endtask

  task automatic send_rx(input logic [DW-1:0] b);
    rx_q.push_back(b);
    exp_push_q.push_back(b);
    refresh();
  endtask

  task automatic load_tx(input logic [DW-1:0] b);
    tx_q.push_back(b);
    exp_start_q.push_back(b);
    refresh();
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      cyc();
      if (idle && rx_q.size() == 0 && tx_q.size() == 0 && exp_push_q.size() == 0 &&
          exp_start_q.size() == 0 && !tx_busy && !tx_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  int p0;

  initial begin
    rst = 1'b1; en = 1'b1; tx_busy = 1'b0; tx_done = 1'b0;
    {s_rx_pop, s_tx_pop, s_tx_push, s_tx_start} = '0;
    s_wdata = '0;
    send_rx(8'h11);
    load_tx(8'h22);

    // reset held with both FIFOs non-empty
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst.rx_pop", 32'(rx_pop), 0);
      chk("rst.tx_push", 32'(tx_push), 0);
      chk("rst.tx_pop", 32'(tx_pop), 0);
      chk("rst.tx_start", 32'(tx_start), 0);
      chk("rst.idle", 32'(idle), 1);
      chk("rst.tx_data", 32'(tx_data), 0);
      chk("rst.tx_wdata", 32'(tx_wdata), 0);
    end
    rst = 1'b0;
    cyc();
    chk("rel.rx_pop", 32'(rx_pop), 1);
    chk("rel.tx_pop", 32'(tx_pop), 1);
    wait_idle("rel.drain");

    // single echo
    p0 = n_tx_push;
    send_rx(8'hA5);
    cyc();
    chk("echo.rx_pop", 32'(rx_pop), 1);
    chk("echo.tx_push_early", 32'(tx_push), 0);
    cyc();
    chk("echo.tx_push", 32'(tx_push), 1);
    chk("echo.tx_wdata", 32'(tx_wdata), 32'hA5);
    cyc();
    chk("echo.back_idle", 32'({rx_pop, tx_push}), 0);
    wait_idle("echo.drain");
    chk("echo.push_cnt", 32'(n_tx_push - p0), 1);

    // backpressure: tx_full high for the first 5 cycles in L_PUSH
    p0 = n_tx_push;
    full_hold = 7;
    send_rx(8'h5A);
    cyc();
    chk("bp.rx_pop", 32'(rx_pop), 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp.held", 32'(tx_push), 0);
    end
    cyc();
    chk("bp.tx_push", 32'(tx_push), 1);
    chk("bp.tx_wdata", 32'(tx_wdata), 32'h5A);
    wait_idle("bp.drain");
    chk("bp.push_cnt", 32'(n_tx_push - p0), 1);
`ifdef UART_SCHED_CNT_EN
    chk("cnt.three", 32'(xfer_cnt), 3);
`endif

    // transmit handshake under bench control
    auto_tx = 1'b0;
    load_tx(8'h3C);
    load_tx(8'h3D);
    cyc();
    chk("hs.tx_pop", 32'(tx_pop), 1);
    chk("hs.start_early", 32'(tx_start), 0);
    cyc();
    chk("hs.tx_start", 32'(tx_start), 1);
    chk("hs.tx_data", 32'(tx_data), 32'h3C);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("hs.no_pop_wait", 32'({tx_pop, tx_start}), 0);
    end
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    chk("hs.done_idle", 32'(idle), 1);
    chk("hs.pop_after_done0", 32'(tx_pop), 0);
    cyc();
    chk("hs.pop_after_done1", 32'(tx_pop), 1);
    cyc();
    chk("hs.tx_data2", 32'(tx_data), 32'h3D);
    cyc();
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    chk("hs.idle2", 32'(idle), 1);
    // stray done while idle
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    cyc();
    chk("hs.stray_done", 32'({idle, tx_pop, tx_start}), 32'b100);
    auto_tx = 1'b1;

    // enable dropped while in L_POP
    send_rx(8'h77);
    cyc();
    chk("en.rx_pop", 32'(rx_pop), 1);
    en = 1'b0;
    send_rx(8'h78);
    cyc();
    chk("en.tx_push", 32'(tx_push), 1);
    chk("en.tx_wdata", 32'(tx_wdata), 32'h77);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("en.parked", 32'({idle, rx_pop, tx_pop}), 32'b100);
    end
    en = 1'b1;
    wait_idle("en.drain");

    // reset while waiting for tx_done
    auto_tx = 1'b0;
    load_tx(8'h9E);
    cyc();
    chk("rw.tx_pop", 32'(tx_pop), 1);
    cyc();
    chk("rw.tx_start", 32'(tx_start), 1);
    cyc();
    chk("rw.wait", 32'({idle, tx_start}), 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rw.idle", 32'(idle), 1);
    chk("rw.tx_data", 32'(tx_data), 0);
`ifdef UART_SCHED_CNT_EN
    chk("rw.cnt_clr", 32'(xfer_cnt), 0);
`endif
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("rw.no_restart", 32'({tx_start, tx_pop}), 0);
    end
    auto_tx = 1'b1;

`ifdef UART_SCHED_CNT_EN
    force dut.cnt_q = 16'hFFFF;
    cyc();
    release dut.cnt_q;
    cyc();
    chk("cnt.preload", 32'(xfer_cnt), 32'hFFFF);
    send_rx(8'hC3);
    wait_idle("cnt.drain");
    chk("cnt.wrap", 32'(xfer_cnt), 0);
`endif

    chk("tot.pop_start", 32'(n_tx_pop), 32'(n_tx_start));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
